// File: rtl/tt_um_reuel_pandher_circuit_sequencer.sv
// Self-test sequencer around the three-input datapath x = (A & B) | ~C, y = ~C.
// Sweeps all eight input vectors with a selectable dwell, captures x/y maps and checks them.
module tt_um_reuel_pandher_circuit_sequencer #(
   parameter logic [7:0] EXP_X = 8'h8F,
   parameter logic [7:0] EXP_Y = 8'h0F
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      APPLY   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic [2:0] idx_q;
   logic [2:0] cnt_q;
   logic [2:0] sync_q;
   logic [1:0] mode_q;
   logic [1:0] s_q;
   logic [7:0] xmap_q;
   logic [7:0] ymap_q;
   logic       done_q;
   logic       pass_q;

   logic       start_pulse;
   logic       run_mode;
   logic       busy;
   logic [2:0] vec;
   logic       x;
   logic       y;
   logic       unused_ok;

   // Dwell counter preload is D-1 where D = 2^s.
   function automatic logic [2:0] dwell_load(input logic [1:0] s);
      case (s)
         2'd0:    return 3'd0;
         2'd1:    return 3'd1;
         2'd2:    return 3'd3;
         default: return 3'd7;
      endcase
   endfunction

   assign start_pulse = sync_q[1] & ~sync_q[2];
   assign run_mode    = (ui_in[2:1] == 2'b01) || (ui_in[2:1] == 2'b10);
   assign busy        = (state_q == APPLY) || (state_q == CAPTURE);
   assign vec         = busy ? idx_q : ui_in[5:3];

   // The datapath under test; A = vec[0], B = vec[1], C = vec[2].
   assign x = (vec[0] & vec[1]) | ~vec[2];
   assign y = ~vec[2];

   assign uo_out    = {pass_q, done_q, busy, vec, y, x};
   assign uio_out   = xmap_q;
   assign uio_oe    = 8'hFF;
   assign unused_ok = &{1'b0, uio_in};

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: begin
            if (start_pulse && run_mode) state_d = APPLY;
         end
         APPLY: begin
            if (start_pulse)       state_d = IDLE;
            else if (cnt_q == 3'd0) state_d = CAPTURE;
         end
         CAPTURE: begin
            if (start_pulse)            state_d = IDLE;
            else if (idx_q != 3'd7)     state_d = APPLY;
            else if (mode_q == 2'b01)   state_d = DONE;
            else                        state_d = APPLY;
         end
         default: state_d = IDLE;
      endcase
   end

   // The index wraps 7 -> 0 on its own, which is what continuous mode needs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= 3'd0;
         cnt_q   <= 3'd0;
         sync_q  <= 3'd0;
         mode_q  <= 2'd0;
         s_q     <= 2'd0;
         xmap_q  <= 8'h00;
         ymap_q  <= 8'h00;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else if (ena) begin
         sync_q  <= {sync_q[1:0], ui_in[0]};
         state_q <= state_d;
         if (start_pulse) begin
            mode_q <= ui_in[2:1];
            s_q    <= ui_in[7:6];
         end
         case (state_q)
            IDLE, DONE: begin
               if (start_pulse && run_mode) begin
                  xmap_q <= 8'h00;
                  ymap_q <= 8'h00;
                  done_q <= 1'b0;
                  pass_q <= 1'b0;
                  idx_q  <= 3'd0;
                  cnt_q  <= dwell_load(ui_in[7:6]);
               end
            end
            APPLY: begin
               if (start_pulse) begin
                  xmap_q <= 8'h00;
                  ymap_q <= 8'h00;
                  done_q <= 1'b0;
                  pass_q <= 1'b0;
                  idx_q  <= 3'd0;
                  cnt_q  <= 3'd0;
               end else begin
                  done_q <= 1'b0;
                  if (cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
               end
            end
            CAPTURE: begin
               if (start_pulse) begin
                  xmap_q <= 8'h00;
                  ymap_q <= 8'h00;
                  done_q <= 1'b0;
                  pass_q <= 1'b0;
                  idx_q  <= 3'd0;
                  cnt_q  <= 3'd0;
               end else begin
                  xmap_q[idx_q] <= x;
                  ymap_q[idx_q] <= y;
                  idx_q         <= idx_q + 3'd1;
                  cnt_q         <= dwell_load(s_q);
                  if (idx_q == 3'd7) begin
                     pass_q <= ({x, xmap_q[6:0]} == EXP_X) && ({y, ymap_q[6:0]} == EXP_Y);
                     done_q <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tt_um_reuel_pandher_circuit_sequencer.sv
// Randomized self-checking bench for the circuit sequencer, using a cycle-schedule reference model.
module tb_tt_um_reuel_pandher_circuit_sequencer;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int errors = 0;
   int checks = 0;

   tt_um_reuel_pandher_circuit_sequencer dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference datapath, straight from the boolean definition: returns {y, x}.
   function automatic logic [1:0] modelXY(input logic [2:0] v);
      logic a, b, c;
      a = v[0];
      b = v[1];
      c = v[2];
      return {!c, (a && b) || !c};
   endfunction

   // Map of the first 'count' vectors; bit i holds x (or y) for vector i.
   function automatic logic [7:0] modelMap(input bit wantY, input int count);
      logic [7:0] m;
      logic [1:0] xy;
      m = 8'h00;
      for (int i = 0; i < count; i++) begin
         xy   = modelXY(3'(i));
         m[i] = wantY ? xy[1] : xy[0];
      end
      return m;
   endfunction

   function automatic logic [5:0] manualLow(input logic [2:0] v);
      return {1'b0, v, modelXY(v)};
   endfunction

   // Raise start and walk the synchronizer latency; returns right after the edge where busy should rise.
   task automatic pulseStart(input bit holdStart);
      ui_in[0] = 1'b0;
      repeat (3) tick;
      ui_in[0] = 1'b1;
      tick;
      checkOutput("lat_n", 32'(uo_out[5]), 32'd0);
      tick;
      checkOutput("lat_n1", 32'(uo_out[5]), 32'd0);
      if (!holdStart) ui_in[0] = 1'b0;
      tick;
   endtask

   task automatic runSingle(input int s, input int freezeAt, input bit holdStart, input bit changeDwell);
      int         d;
      int         total;
      logic [2:0] v;
      logic [5:0] expLow;
      d     = 1 << s;
      total = 8 * (d + 1);
      ui_in = {2'(s), 3'($urandom), 2'b01, 1'b0};
      pulseStart(holdStart);
      for (int k = 0; k < total; k++) begin
         v      = 3'(k / (d + 1));
         expLow = {1'b1, v, modelXY(v)};
         checkOutput("sweep", 32'(uo_out[5:0]), 32'(expLow));
         checkOutput("xmap_live", 32'(uio_out), 32'(modelMap(0, k / (d + 1))));
         if (k == freezeAt) begin
            ena = 1'b0;
            for (int j = 0; j < 10; j++) begin
               tick;
               checkOutput("freeze", 32'(uo_out[5:0]), 32'(expLow));
            end
            ena = 1'b1;
         end
         ui_in[5:3] = 3'($urandom);
         if (changeDwell && k == total / 2) begin
            ui_in[7:6] = 2'($urandom);
            ui_in[2:1] = 2'b10;
         end
         tick;
      end
      checkOutput("end_flags", 32'(uo_out[7:5]), 32'b110);
      checkOutput("end_xmap", 32'(uio_out), 32'(modelMap(0, 8)));
      checkOutput("done_manual", 32'(uo_out[4:0]), 32'(manualLow(ui_in[5:3])));
      ui_in[0] = 1'b0;
   endtask

   task automatic runContinuous;
      logic [2:0] v;
      ui_in = {2'd1, 3'($urandom), 2'b10, 1'b0};
      pulseStart(0);
      for (int k = 0; k < 60; k++) begin
         v = 3'((k % 24) / 3);
         checkOutput("cont", 32'(uo_out),
                     32'({(k >= 24) ? 1'b1 : 1'b0, (k > 0 && k % 24 == 0) ? 1'b1 : 1'b0, 1'b1, v, modelXY(v)}));
         checkOutput("cont_xmap", 32'(uio_out), 32'((k < 24) ? modelMap(0, k / 3) : modelMap(0, 8)));
         tick;
      end
      ui_in[0] = 1'b1;
      tick;
      checkOutput("abort_m", 32'(uo_out[5]), 32'd1);
      tick;
      checkOutput("abort_m1", 32'(uo_out[5]), 32'd1);
      tick;
      checkOutput("abort_flags", 32'(uo_out[7:5]), 32'd0);
      checkOutput("abort_xmap", 32'(uio_out), 32'd0);
      checkOutput("abort_manual", 32'(uo_out[4:0]), 32'(manualLow(ui_in[5:3])));
      ui_in[0] = 1'b0;
   endtask

   task automatic applyStimulus;
      logic [2:0] mv;
      int         s;
      // Manual passthrough, including the two named corner vectors.
      ui_in = 8'h00;
      for (int n = 0; n < 10; n++) begin
         mv = (n == 0) ? 3'b011 : (n == 1) ? 3'b100 : 3'($urandom);
         ui_in = {2'($urandom), mv, 2'b00, 1'b0};
         #1;
         checkOutput("manual", 32'(uo_out), 32'({2'b00, manualLow(mv)}));
         tick;
      end

      runSingle(0, -1, 0, 0);
      runSingle(3, -1, 1, 1);
      s = $urandom_range(0, 3);
      runSingle(s, $urandom_range(1, 8 * ((1 << s) + 1) - 2), 0, 0);
      runSingle($urandom_range(0, 3), -1, 0, 1);
      runContinuous();

      // Reserved mode 11 behaves like manual.
      mv    = 3'($urandom);
      ui_in = {2'($urandom), mv, 2'b11, 1'b0};
      repeat (3) tick;
      ui_in[0] = 1'b1;
      for (int n = 0; n < 6; n++) begin
         tick;
         checkOutput("reserved", 32'(uo_out[5:0]), 32'(manualLow(mv)));
      end
      ui_in[0] = 1'b0;

      // Asynchronous reset in the middle of vector 5.
      s     = $urandom_range(0, 3);
      mv    = 3'($urandom);
      ui_in = {2'(s), mv, 2'b01, 1'b0};
      pulseStart(0);
      repeat (5 * ((1 << s) + 1)) tick;
      checkOutput("at_vec5", 32'(uo_out[4:2]), 32'd5);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_flags", 32'(uo_out[7:5]), 32'd0);
      checkOutput("rst_xmap", 32'(uio_out), 32'd0);
      checkOutput("rst_manual", 32'(uo_out[4:0]), 32'(manualLow(mv)));
      tick;
      rst_n = 1'b1;
      repeat (3) tick;
      checkOutput("rst_idle", 32'(uo_out[7:5]), 32'd0);
   endtask

   initial begin
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'($urandom);
      #12;
      checkOutput("reset_uo", 32'(uo_out), 32'({2'b00, manualLow(3'd0)}));
      checkOutput("reset_uio", 32'(uio_out), 32'h00);
      checkOutput("reset_oe", 32'(uio_oe), 32'hFF);
      rst_n = 1'b1;
      tick;
      applyStimulus();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tt_um_reuel_pandher_circuit_sequencer.md
# tt_um_reuel_pandher_circuit_sequencer

Self-test sequencer for the team's three-input logic datapath (x = (A AND B) OR NOT C, y = NOT C), instantiated inside the block. It sweeps the 8 input vectors with a selectable dwell time and captures x and y for each vector into result maps. It then compares the maps against expected signatures and reports busy, done and pass on the TinyTapeout pins. A manual passthrough mode keeps the original direct-drive behaviour available.

## Interface
- EXP_X, 8'h8F, expected x map (bit i = x for vector i)
- EXP_Y, 8'h0F, expected y map (bit i = y for vector i)
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset; one clock domain
- ena  in  1  0 freezes all state, including the synchronizer; outputs hold
- ui_in  in  8  [0] start; [2:1] mode (00 manual, 01 single sweep, 10 continuous, 11 treated as 00); [5:3] manual vector C,B,A; [7:6] dwell select s
- uo_out  out  8  [0] x; [1] y; [4:2] applied vector {C,B,A}; [5] busy; [6] done; [7] pass
- uio_in  in  8  unused
- uio_out  out  8  live captured x map
- uio_oe  out  8  constant 8'hFF

## Operation
- Vector index i[2:0] maps to datapath inputs A=i[0], B=i[1], C=i[2].
- Start path: ui_in[0] passes through a 2-flop synchronizer. A rising-edge detect on the synchronized value produces start_pulse.
- On start_pulse, mode_q and s_q are latched from ui_in[2:1] and ui_in[7:6]. Later mode or dwell changes are ignored until the next start.
- FSM states: IDLE, APPLY, CAPTURE, DONE.
- IDLE
  - Applied vector is ui_in[5:3], combinational path to x and y.
  - start_pulse with mode 01 or 10: clear xmap, ymap, pass and done; set i=0; go to APPLY.
  - start_pulse with mode 00 or 11: stay in IDLE.
- APPLY
  - Applied vector is i.
  - Dwell counter loads D-1, with D = 2^s_q (1, 2, 4 or 8), and decrements each cycle.
  - When the counter reaches 0, go to CAPTURE.
- CAPTURE (1 cycle)
  - At the exiting edge: xmap[i] <= x and ymap[i] <= y.
  - If i<7: i <= i+1, go to APPLY.
  - If i==7: pass <= ({x,xmap[6:0]}==EXP_X && {y,ymap[6:0]}==EXP_Y). The comparison uses the bits being written this cycle.
  - i==7, mode 01: go to DONE.
  - i==7, mode 10: done pulses for 1 cycle, i wraps to 0, go to APPLY. Maps are overwritten bitwise, never cleared, in continuous mode.
- DONE
  - done=1, pass held, applied vector is ui_in[5:3].
  - start_pulse restarts exactly as from IDLE.
- start_pulse while busy (APPLY or CAPTURE): abort to IDLE, clear maps, done and pass; i=0.
- busy = 1 in APPLY and CAPTURE; otherwise 0.

## Timing
- Reset values
  - State IDLE, i=0, counter 0, synchronizer 0, mode_q/s_q 0.
  - xmap, ymap, busy, done, pass all 0; uio_out 8'h00.
  - uo_out[4:2] follows ui_in[5:3]; uo_out[1:0] follows it combinationally.
- Start latency: ui_in[0] sampled high at edge N gives busy=1 after edge N+2.
- Per-vector time is D+1 cycles; a full sweep is 8(D+1) cycles from the first APPLY cycle.
- Single mode: done and pass become valid in the same cycle busy falls.
- Continuous mode: done is high for exactly 1 cycle per sweep, coincident with the pass update; busy stays 1.
- Boundary conditions
  - rst_n assertion mid-sweep clears everything immediately (asynchronous).
  - Start held high gives only one start_pulse.
  - ena=0 during APPLY does not advance the dwell counter or i.
  - s_q=0 (D=1) gives APPLY 1 cycle, CAPTURE 1 cycle.

## Test plan
- Manual mode, vectors: ui_in[2:1]=00.
  - ui_in[5:3]=3'b011 (A=1, B=1, C=0) -> uo_out[1:0]=2'b11.
  - ui_in[5:3]=3'b100 -> uo_out[1:0]=2'b00.
  - uo_out[4:2] equals ui_in[5:3]; busy=0.
- Single sweep, s=0: pulse start -> busy rises at edge N+2; uo_out[4:2] steps 0..7, 2 cycles each; after 16 cycles busy=0, done=1, uio_out=8'h8F, pass=1.
- Single sweep, s=3: each vector held 8 APPLY + 1 CAPTURE cycles; busy high exactly 72 cycles; final uio_out=8'h8F, pass=1. Changing ui_in[7:6] mid-sweep has no effect.
- Continuous, s=1: done pulses 1 cycle every 24 cycles with pass=1 and busy constantly 1; a second start pulse -> IDLE next cycle with busy=0, done=0, uio_out=8'h00.
- Freeze, reset and abort:
  - ena=0 for 10 cycles mid-sweep -> uo_out[4:2] and the counter hold; resuming completes with the total cycle count extended by exactly 10.
  - rst_n low at vector 5 -> all outputs return to reset values asynchronously.
- Reserved mode: start with ui_in[2:1]=11 -> busy stays 0 and the manual path stays active.
